fmc_burst_reader: RTL and testbench

FPGA-side reader for the 128-bit bidirectional FMC data bus to the test chip. On request it releases the bus with a one-cycle turnaround and asserts the chip's output-enable request. It then captures a burst of chip-driven words under a ready/valid handshake into a local FIFO, and returns the bus to FPGA drive. It sits next to the FPGA pin-driving top and is the receive counterpart to the FPGA-to-chip write path.

---
 rtl/fmc_pkg.sv | 15 +
 rtl/fmc_sync_fifo.sv | 56 +++++
 rtl/fmc_burst_reader.sv | 131 +++++++++++++
 tb/tb_fmc_burst_reader.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fmc_pkg.sv
// fmc_pkg: shared types and widths for the FMC receive path.
// Holds the reader state enum and the default pad/length widths.
package fmc_pkg;

  localparam int FMC_DATA_W = 128;
  localparam int FMC_LEN_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TURN_IN,
    ST_REQ,
    ST_TURN_OUT
  } fmc_rd_state_t;

endpackage

// File: rtl/fmc_sync_fifo.sv
// fmc_sync_fifo: single-clock show-ahead FIFO for captured words.
// Ports: wr/wdata push, rd pop, rdata head, full/empty, free, ovf_pulse.
module fmc_sync_fifo #(
  parameter int W     = 128,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr,
  input  logic [W-1:0]  wdata,
  input  logic          rd,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   free,
  output logic          ovf_pulse
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;
  logic          do_rd;
  logic          do_wr;

  assign empty = (cnt == '0);
  assign full  = (cnt == (AW+1)'(DEPTH));
  assign free  = (AW+1)'(DEPTH) - cnt;
  assign do_rd = rd & ~empty;
  // A pop in the same cycle frees the slot, so full+pop still accepts.
  assign do_wr = wr & (~full | do_rd);
  assign ovf_pulse = wr & ~do_wr;
  assign rdata = empty ? '0 : mem[rp];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_wr) wp <= wp + 1'b1;
      if (do_rd) rp <= rp + 1'b1;
      unique case ({do_wr, do_rd})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wp] <= wdata;
  end

endmodule

// File: rtl/fmc_burst_reader.sv
// fmc_burst_reader: turns the FMC bus around, captures a chip burst into a FIFO.
// Ports: rd_start/len request, bus_oe/OE_req ownership, wr_val/wr_rdy capture, data/val/rdy out.
module fmc_burst_reader
  import fmc_pkg::*;
#(
  parameter int DATA_W     = FMC_DATA_W,
  parameter int LEN_W      = FMC_LEN_W,
  parameter int FIFO_DEPTH = 16,
  parameter int SKID       = 2
) (
  input  logic              I_clk,
  input  logic              I_reset_n,
  input  logic              I_rd_start,
  input  logic [LEN_W-1:0]  I_rd_len,
  output logic              O_bus_oe,
  output logic              O_OE_req,
  input  logic [DATA_W-1:0] I_spi_data,
  input  logic              I_ASICGB_wr_val,
  output logic              O_ASICGB_wr_rdy,
  output logic [DATA_W-1:0] O_data,
  output logic              O_val,
  input  logic              I_rdy,
  output logic              O_busy,
  output logic              O_done,
  output logic              O_ovf
);

  localparam int AW = $clog2(FIFO_DEPTH);

  fmc_rd_state_t     state;
  logic              start_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt;
  logic              in_v;
  logic [DATA_W-1:0] in_d;
  logic              full;
  logic              empty;
  logic              ovf_pulse;
  logic [AW:0]       free;
  logic [AW:0]       avail;
  logic              cap;

  // Once the count hits len, late strobes are not captured.
  assign cap = (state == ST_REQ) & I_ASICGB_wr_val & (cnt != len_q);

  // The word sitting in the input register already owns a slot.
  assign avail = free - {{AW{1'b0}}, in_v};

  assign O_ASICGB_wr_rdy = (state == ST_REQ) & ~full
                         & (avail > (AW+1)'(SKID));

  assign O_val = ~empty;

  // Start is registered first, so every pad change lands one edge later.
  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      state    <= ST_IDLE;
      start_q  <= 1'b0;
      len_q    <= '0;
      cnt      <= '0;
      in_v     <= 1'b0;
      in_d     <= '0;
      O_bus_oe <= 1'b1;
      O_OE_req <= 1'b0;
      O_busy   <= 1'b0;
      O_done   <= 1'b0;
      O_ovf    <= 1'b0;
    end else begin
      O_done <= 1'b0;
      in_v   <= cap;
      if (cap) begin
        in_d <= I_spi_data;
        cnt  <= cnt + 1'b1;
      end
      if (ovf_pulse) O_ovf <= 1'b1;
      unique case (state)
        ST_IDLE: begin
          if (start_q) begin
            start_q <= 1'b0;
            if (len_q != '0) begin
              state    <= ST_TURN_IN;
              O_bus_oe <= 1'b0;
              O_busy   <= 1'b1;
              cnt      <= '0;
              if (!ovf_pulse) O_ovf <= 1'b0;
            end else begin
              O_done <= 1'b1;
            end
          end else if (I_rd_start) begin
            start_q <= 1'b1;
            len_q   <= I_rd_len;
          end
        end
        ST_TURN_IN: begin
          state    <= ST_REQ;
          O_OE_req <= 1'b1;
        end
        ST_REQ: begin
          if (cnt == len_q) begin
            state    <= ST_TURN_OUT;
            O_OE_req <= 1'b0;
          end
        end
        ST_TURN_OUT: begin
          state    <= ST_IDLE;
          O_bus_oe <= 1'b1;
          O_busy   <= 1'b0;
          O_done   <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  fmc_sync_fifo #(
    .W     (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (I_clk),
    .rst_n     (I_reset_n),
    .wr        (in_v),
    .wdata     (in_d),
    .rd        (I_rdy),
    .rdata     (O_data),
    .full      (full),
    .empty     (empty),
    .free      (free),
    .ovf_pulse (ovf_pulse)
  );

endmodule

// File: tb/tb_fmc_burst_reader.sv
// tb_fmc_burst_reader: directed bench with a scoreboard queue for fmc_burst_reader.
// Covers turnaround timing, skid flow control, overflow, zero length and async reset.
module tb_fmc_burst_reader;

  logic         I_clk = 1'b0;
  logic         I_reset_n;
  logic         I_rd_start;
  logic [15:0]  I_rd_len;
  logic         O_bus_oe;
  logic         O_OE_req;
  logic [127:0] I_spi_data;
  logic         I_ASICGB_wr_val;
  logic         O_ASICGB_wr_rdy;
  logic [127:0] O_data;
  logic         O_val;
  logic         I_rdy;
  logic         O_busy;
  logic         O_done;
  logic         O_ovf;

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;
  logic [127:0] sb[$];

  fmc_burst_reader dut (
    .I_clk           (I_clk),
    .I_reset_n       (I_reset_n),
    .I_rd_start      (I_rd_start),
    .I_rd_len        (I_rd_len),
    .O_bus_oe        (O_bus_oe),
    .O_OE_req        (O_OE_req),
    .I_spi_data      (I_spi_data),
    .I_ASICGB_wr_val (I_ASICGB_wr_val),
    .O_ASICGB_wr_rdy (O_ASICGB_wr_rdy),
    .O_data          (O_data),
    .O_val           (O_val),
    .I_rdy           (I_rdy),
    .O_busy          (O_busy),
    .O_done          (O_done),
    .O_ovf           (O_ovf)
  );

  always #5 I_clk = ~I_clk;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge I_clk);
    #1;
  endtask

  task automatic start_burst(input int len);
    I_rd_start = 1'b1;
    I_rd_len = 16'(len);
    tick;
    I_rd_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < budget; c++) begin
      tick;
      if (O_done) begin
        seen = 1'b1;
        break;
      end
    end
    chk(tag, {127'd0, seen}, 128'd1);
  endtask

  task automatic drain(input string tag);
    for (int c = 0; c < 60 && sb.size() != 0; c++) tick;
    chk(tag, 128'(sb.size()), 128'd0);
  endtask

  // Consumer side: pop and compare on every accepted head word.
  always @(negedge I_clk) begin
    if (I_reset_n) begin
      chk("no_overlap", {127'd0, O_bus_oe & O_OE_req}, 128'd0);
      if (O_val && I_rdy) begin
        if (sb.size() == 0) chk("sb_extra", 128'(sb.size()), 128'd1);
        else chk("data", O_data, sb.pop_front());
      end
    end
  end

  initial begin
    int sent;
    int guard;
    logic seen;

    I_reset_n = 1'b0;
    I_rd_start = 1'b0;
    I_rd_len = '0;
    I_spi_data = '0;
    I_ASICGB_wr_val = 1'b0;
    I_rdy = 1'b0;
    repeat (3) tick;
    chk("rst_oe", {127'd0, O_bus_oe}, 128'd1);
    chk("rst_req", {127'd0, O_OE_req}, 128'd0);
    chk("rst_rdy", {127'd0, O_ASICGB_wr_rdy}, 128'd0);
    chk("rst_val", {127'd0, O_val}, 128'd0);
    chk("rst_data", O_data, 128'd0);
    chk("rst_busy", {127'd0, O_busy}, 128'd0);
    chk("rst_done", {127'd0, O_done}, 128'd0);
    chk("rst_ovf", {127'd0, O_ovf}, 128'd0);
    #3 I_reset_n = 1'b1;
    tick;
    tick;

    // Basic burst of four back-to-back words.
    I_rdy = 1'b1;
    start_burst(4);
    chk("b_oe_t0", {127'd0, O_bus_oe}, 128'd1);
    tick;
    chk("b_oe_t1", {127'd0, O_bus_oe}, 128'd0);
    chk("b_req_t1", {127'd0, O_OE_req}, 128'd0);
    chk("b_busy_t1", {127'd0, O_busy}, 128'd1);
    tick;
    chk("b_req_t2", {127'd0, O_OE_req}, 128'd1);
    chk("b_rdy_t2", {127'd0, O_ASICGB_wr_rdy}, 128'd1);
    for (int i = 1; i <= 4; i++) begin
      I_ASICGB_wr_val = 1'b1;
      I_spi_data = 128'(i);
      sb.push_back(128'(i));
      tick;
    end
    I_ASICGB_wr_val = 1'b0;
    chk("b_req_k", {127'd0, O_OE_req}, 128'd1);
    tick;
    chk("b_req_k1", {127'd0, O_OE_req}, 128'd0);
    chk("b_oe_k1", {127'd0, O_bus_oe}, 128'd0);
    chk("b_done_k1", {127'd0, O_done}, 128'd0);
    tick;
    chk("b_oe_k2", {127'd0, O_bus_oe}, 128'd1);
    chk("b_done_k2", {127'd0, O_done}, 128'd1);
    chk("b_sb_empty", 128'(sb.size()), 128'd0);
    chk("b_val_k2", {127'd0, O_val}, 128'd0);
    tick;
    chk("b_done_off", {127'd0, O_done}, 128'd0);
    chk("b_ovf", {127'd0, O_ovf}, 128'd0);

    // Zero-length request.
    start_burst(0);
    chk("z_done_t0", {127'd0, O_done}, 128'd0);
    tick;
    chk("z_done_t1", {127'd0, O_done}, 128'd1);
    chk("z_oe_t1", {127'd0, O_bus_oe}, 128'd1);
    chk("z_req_t1", {127'd0, O_OE_req}, 128'd0);
    tick;
    chk("z_done_off", {127'd0, O_done}, 128'd0);
    chk("z_req_t2", {127'd0, O_OE_req}, 128'd0);
    chk("z_busy", {127'd0, O_busy}, 128'd0);

    // Chip ignores wr_rdy: first 16 kept, rest dropped.
    I_rdy = 1'b0;
    start_burst(20);
    tick;
    tick;
    for (int i = 0; i < 20; i++) begin
      I_ASICGB_wr_val = 1'b1;
      I_spi_data = 128'h200 + 128'(i);
      if (i < 16) sb.push_back(128'h200 + 128'(i));
      tick;
    end
    I_ASICGB_wr_val = 1'b0;
    wait_done("o_done", 10);
    chk("o_ovf", {127'd0, O_ovf}, 128'd1);
    chk("o_head", O_data, 128'h200);
    I_rdy = 1'b1;
    drain("o_drain");
    tick;
    chk("o_val_empty", {127'd0, O_val}, 128'd0);

    // Chip honours wr_rdy with FIFO stalled.
    I_rdy = 1'b0;
    start_burst(20);
    tick;
    tick;
    chk("s_ovf_clr", {127'd0, O_ovf}, 128'd0);
    sent = 0;
    guard = 0;
    while (O_ASICGB_wr_rdy && sent < 20 && guard < 100) begin
      I_ASICGB_wr_val = 1'b1;
      I_spi_data = 128'h300 + 128'(sent);
      sb.push_back(128'h300 + 128'(sent));
      sent++;
      guard++;
      tick;
    end
    I_ASICGB_wr_val = 1'b0;
    chk("s_fall_words", 128'(sent), 128'd14);
    repeat (3) tick;
    chk("s_rdy_low", {127'd0, O_ASICGB_wr_rdy}, 128'd0);
    chk("s_ovf_mid", {127'd0, O_ovf}, 128'd0);
    chk("s_head", O_data, 128'h300);
    I_rdy = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (sent < 20 && O_ASICGB_wr_rdy) begin
        I_ASICGB_wr_val = 1'b1;
        I_spi_data = 128'h300 + 128'(sent);
        sb.push_back(128'h300 + 128'(sent));
        sent++;
      end else begin
        I_ASICGB_wr_val = 1'b0;
      end
      tick;
      if (O_done) begin
        seen = 1'b1;
        break;
      end
    end
    I_ASICGB_wr_val = 1'b0;
    chk("s_done", {127'd0, seen}, 128'd1);
    chk("s_sent", 128'(sent), 128'd20);
    chk("s_ovf_end", {127'd0, O_ovf}, 128'd0);
    drain("s_drain");

    // Async reset in the middle of a burst.
    I_rdy = 1'b0;
    start_burst(8);
    tick;
    tick;
    for (int i = 0; i < 3; i++) begin
      I_ASICGB_wr_val = 1'b1;
      I_spi_data = 128'h400 + 128'(i);
      sb.push_back(128'h400 + 128'(i));
      tick;
    end
    I_ASICGB_wr_val = 1'b0;
    tick;
    tick;
    chk("r_val_pre", {127'd0, O_val}, 128'd1);
    chk("r_req_pre", {127'd0, O_OE_req}, 128'd1);
    #2 I_reset_n = 1'b0;
    #1;
    chk("r_req", {127'd0, O_OE_req}, 128'd0);
    chk("r_oe", {127'd0, O_bus_oe}, 128'd1);
    chk("r_val", {127'd0, O_val}, 128'd0);
    chk("r_data", O_data, 128'd0);
    chk("r_busy", {127'd0, O_busy}, 128'd0);
    chk("r_rdy", {127'd0, O_ASICGB_wr_rdy}, 128'd0);
    sb.delete();
    #3 I_reset_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick;
      if (O_done) seen = 1'b1;
    end
    chk("r_no_done", {127'd0, seen}, 128'd0);
    I_rdy = 1'b1;
    start_burst(2);
    tick;
    tick;
    chk("r2_req", {127'd0, O_OE_req}, 128'd1);
    for (int i = 0; i < 2; i++) begin
      I_ASICGB_wr_val = 1'b1;
      I_spi_data = 128'h500 + 128'(i);
      sb.push_back(128'h500 + 128'(i));
      tick;
    end
    I_ASICGB_wr_val = 1'b0;
    wait_done("r2_done", 10);
    chk("r2_oe", {127'd0, O_bus_oe}, 128'd1);
    drain("r2_drain");
    chk("r2_ovf", {127'd0, O_ovf}, 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
